// File: rtl/neosd_dat_rx.sv
// neosd_dat_rx: SD DAT0 receive path.
// Handles start-bit search, MSB-first byte assembly into a small FWFT FIFO,
// 16-bit CRC field, end bit and busy-release detection with timeout.
// Optional feature macro: NEOSD_DAT_CRC16_EN, which enables CRC16-CCITT
// checking of the data bits against the received CRC field.
module neosd_dat_rx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    input  logic [1:0] mode_i,
    input  logic [9:0] blk_len_i,
    input  logic       abort_i,
    input  logic       bit_stb_i,
    input  logic       sd_dat0_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       crc_err_o,
    output logic       ovr_err_o,
    output logic       tmo_err_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    // The strobe that would bring the counter to all-ones is the one that times out.
    localparam logic [TIMEOUT_W-1:0] TMO_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_END,
        S_BUSY_WAIT
    } state_t;

    typedef enum logic [1:0] {
        M_NONE  = 2'd0,
        M_BUSY  = 2'd1,
        M_READ  = 2'd2,
        M_WRITE = 2'd3
    } mode_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic [TIMEOUT_W-1:0]   r_tmo_cnt;
    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_byte_cnt;
    logic [9:0]             r_last_byte;
    logic [6:0]             r_shift;
    logic                   r_crc_err;
    logic                   r_ovr_err;
    logic                   r_tmo_err;
    logic [PW:0]            r_wr_ptr;
    logic [PW:0]            r_rd_ptr;
    logic [7:0]             r_mem [FIFO_DEPTH];

    logic                   w_start_acc;
    logic                   w_tmo_inc;
    logic                   w_tmo_last;
    logic                   w_cnt_clr;
    logic                   w_data_stb;
    logic                   w_crc_stb;
    logic                   w_push;
    logic                   w_push_acc;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_set_tmo;
    logic                   w_set_crc;
    logic                   w_crc_bad;
    logic [7:0]             w_push_byte;
    logic [9:0]             w_last_byte;

    assign w_tmo_last  = (r_tmo_cnt == TMO_PRE);
    assign w_push_byte = {r_shift, sd_dat0_i};
    assign w_last_byte = (blk_len_i == '0) ? 10'd511 : (blk_len_i - 10'd1);

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                          (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign byte_valid_o = ~w_empty;
    assign byte_o       = r_mem[r_rd_ptr[PW-1:0]];
    assign w_pop        = byte_valid_o & byte_ready_i;
    assign w_push_acc   = w_push & (~w_full | w_pop);

    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign crc_err_o = r_crc_err;
    assign ovr_err_o = r_ovr_err;
    assign tmo_err_o = r_tmo_err;

`ifdef NEOSD_DAT_CRC16_EN
    logic [15:0] r_crc_calc;
    logic [15:0] r_crc_rx;
    logic [15:0] w_crc_nxt;

    assign w_crc_nxt = {r_crc_calc[14:0], 1'b0} ^
                       ((r_crc_calc[15] ^ sd_dat0_i) ? 16'h1021 : 16'h0000);
    assign w_crc_bad = (r_crc_calc != r_crc_rx);

    // CRC accumulation over data bits and capture of the received CRC field
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_crc_calc <= '0;
            r_crc_rx   <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_crc_calc <= '0;
            end else if (w_data_stb) begin
                r_crc_calc <= w_crc_nxt;
            end
            if (w_crc_stb) begin
                r_crc_rx <= {r_crc_rx[14:0], sd_dat0_i};
            end
        end
    end
`else
    assign w_crc_bad = 1'b0;
`endif

    // Next-state and control decode; abort overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_start_acc = 1'b0;
        w_tmo_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_data_stb  = 1'b0;
        w_crc_stb   = 1'b0;
        w_push      = 1'b0;
        w_set_tmo   = 1'b0;
        w_set_crc   = 1'b0;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_start_acc = 1'b1;
                        case (mode_t'(mode_i))
                            M_READ:  w_state_nxt = S_WAIT_START;
                            M_BUSY:  w_state_nxt = S_BUSY_WAIT;
                            default: w_done_nxt  = 1'b1;
                        endcase
                    end
                end
                S_WAIT_START: begin
                    if (bit_stb_i) begin
                        if (!sd_dat0_i) begin
                            w_state_nxt = S_DATA;
                            w_cnt_clr   = 1'b1;
                        end else if (w_tmo_last) begin
                            w_state_nxt = S_IDLE;
                            w_set_tmo   = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_tmo_inc = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_stb_i) begin
                        w_data_stb = 1'b1;
                        if (r_bit_cnt[2:0] == 3'd7) begin
                            w_push = 1'b1;
                            if (r_byte_cnt == r_last_byte) begin
                                w_state_nxt = S_CRC;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (bit_stb_i) begin
                        w_crc_stb = 1'b1;
                        if (r_bit_cnt == 4'd15) begin
                            w_state_nxt = S_END;
                        end
                    end
                end
                S_END: begin
                    if (bit_stb_i) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        w_set_crc   = ~sd_dat0_i | w_crc_bad;
                    end
                end
                S_BUSY_WAIT: begin
                    if (bit_stb_i) begin
                        if (sd_dat0_i) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (w_tmo_last) begin
                            w_state_nxt = S_IDLE;
                            w_set_tmo   = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_tmo_inc = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and registered completion pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Timeout, bit/byte counters and data shifter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tmo_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_last_byte <= '0;
            r_shift     <= '0;
        end else begin
            if (w_start_acc) begin
                r_tmo_cnt   <= '0;
                r_last_byte <= w_last_byte;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            end
            // The bit counter wraps to zero on the last data byte, so it is
            // already cleared for counting the CRC field.
            if (w_cnt_clr) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else if (w_data_stb) begin
                r_shift <= w_push_byte[6:0];
                if (r_bit_cnt[2:0] == 3'd7) begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= r_byte_cnt + 10'd1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_crc_stb) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    // Sticky error flags, cleared only by an accepted start
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_crc_err <= 1'b0;
            r_ovr_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else if (w_start_acc) begin
            r_crc_err <= 1'b0;
            r_ovr_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_set_crc)                   r_crc_err <= 1'b1;
            if (w_set_tmo)                   r_tmo_err <= 1'b1;
            if (w_push && w_full && !w_pop)  r_ovr_err <= 1'b1;
        end
    end

    // FIFO pointers; abort flushes the FIFO
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (abort_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage, not reset
    always_ff @(posedge clk_i) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr[PW-1:0]] <= w_push_byte;
        end
    end

endmodule

// File: tb/tb_neosd_dat_rx.sv
// Self-checking bench for neosd_dat_rx (FIFO_DEPTH=4, TIMEOUT_W=4).
module tb_neosd_dat_rx;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic [9:0] blk_len_i = 10'd0;
    logic       abort_i = 1'b0;
    logic       bit_stb_i = 1'b0;
    logic       sd_dat0_i = 1'b1;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i = 1'b0;
    logic       busy_o;
    logic       done_o;
    logic       crc_err_o;
    logic       ovr_err_o;
    logic       tmo_err_o;

    localparam logic [1:0] MD_NONE  = 2'd0;
    localparam logic [1:0] MD_BUSY  = 2'd1;
    localparam logic [1:0] MD_READ  = 2'd2;
    localparam logic [1:0] MD_WRITE = 2'd3;

`ifdef NEOSD_DAT_CRC16_EN
    localparam logic EXP_FLIP_ERR = 1'b1;
`else
    localparam logic EXP_FLIP_ERR = 1'b0;
`endif

    int unsigned errors   = 0;
    int unsigned checks   = 0;
    int unsigned done_cnt = 0;
    int unsigned d0;
    logic [7:0]  exp_q [$];
    logic [7:0]  tx_bytes [8];
    logic [7:0]  mon_exp;
    logic [15:0] good_crc;

    neosd_dat_rx #(
        .FIFO_DEPTH(4),
        .TIMEOUT_W (4)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .blk_len_i   (blk_len_i),
        .abort_i     (abort_i),
        .bit_stb_i   (bit_stb_i),
        .sd_dat0_i   (sd_dat0_i),
        .byte_o      (byte_o),
        .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .crc_err_o   (crc_err_o),
        .ovr_err_o   (ovr_err_o),
        .tmo_err_o   (tmo_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Done-pulse counter and scoreboard pop, sampled on the falling edge
    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_cnt++;
        if (rstn_i === 1'b1 && byte_valid_o === 1'b1 && byte_ready_i === 1'b1) begin
            check("pop_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("pop_byte", {24'd0, byte_o}, {24'd0, mon_exp});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sd_dat0_i = b;
        bit_stb_i = 1'b1;
        tick(1);
        bit_stb_i = 1'b0;
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [9:0] len);
        mode_i    = m;
        blk_len_i = len;
        start_i   = 1'b1;
        tick(1);
        start_i   = 1'b0;
    endtask

    task automatic send_head();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
    endtask

    task automatic send_tail(input logic [15:0] crc, input logic endb);
        for (int i = 15; i >= 0; i--) send_bit(crc[i]);
        send_bit(endb);
    endtask

    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ tx_bytes[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        check(tag, exp_q.size(), 32'd0);
    endtask

    task automatic load_deadbeef();
        tx_bytes[0] = 8'hDE;
        tx_bytes[1] = 8'hAD;
        tx_bytes[2] = 8'hBE;
        tx_bytes[3] = 8'hEF;
    endtask

    task automatic good_read(input string tag);
        load_deadbeef();
        good_crc     = crc16(4);
        byte_ready_i = 1'b1;
        d0 = done_cnt;
        do_start(MD_READ, 10'd4);
        send_head();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(tx_bytes[k]);
            send_byte(tx_bytes[k]);
        end
        send_tail(good_crc, 1'b1);
        tick(2);
        wait_drain({tag, "_drain"});
        check({tag, "_done"}, done_cnt - d0, 32'd1);
        check({tag, "_crc_err"}, crc_err_o, 1'b0);
        check({tag, "_ovr_err"}, ovr_err_o, 1'b0);
        check({tag, "_tmo_err"}, tmo_err_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        tick(3);
        rstn_i = 1'b1;
        tick(1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_valid", byte_valid_o, 1'b0);
        check("rst_crc_err", crc_err_o, 1'b0);
        check("rst_ovr_err", ovr_err_o, 1'b0);
        check("rst_tmo_err", tmo_err_o, 1'b0);

        // NONE: done exactly one cycle later, busy never rises
        d0 = done_cnt;
        do_start(MD_NONE, 10'd4);
        check("none_done_t1", done_o, 1'b1);
        check("none_busy_t1", busy_o, 1'b0);
        tick(1);
        check("none_done_t2", done_o, 1'b0);
        check("none_busy_t2", busy_o, 1'b0);
        check("none_done_cnt", done_cnt - d0, 32'd1);

        do_start(MD_WRITE, 10'd4);
        check("write_done", done_o, 1'b1);
        tick(1);

        // Good READ frame
        good_read("read1");

        // Flipped CRC bit
        load_deadbeef();
        good_crc = crc16(4);
        d0 = done_cnt;
        do_start(MD_READ, 10'd4);
        send_head();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(tx_bytes[k]);
            send_byte(tx_bytes[k]);
        end
        send_tail(good_crc ^ 16'h0100, 1'b1);
        tick(2);
        wait_drain("flip_drain");
        check("flip_crc_err", crc_err_o, EXP_FLIP_ERR);
        check("flip_done", done_cnt - d0, 32'd1);

        // Bad end bit
        d0 = done_cnt;
        do_start(MD_READ, 10'd4);
        check("endbit_crc_clr", crc_err_o, 1'b0);
        send_head();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(tx_bytes[k]);
            send_byte(tx_bytes[k]);
        end
        send_tail(good_crc, 1'b0);
        tick(2);
        wait_drain("endbit_drain");
        check("endbit_crc_err", crc_err_o, 1'b1);
        check("endbit_done", done_cnt - d0, 32'd1);

        // Overflow: 8 bytes, consumer stalled, FIFO holds 4
        for (int k = 0; k < 8; k++) tx_bytes[k] = 8'(8'h11 * (k + 1));
        good_crc     = crc16(8);
        byte_ready_i = 1'b0;
        d0 = done_cnt;
        do_start(MD_READ, 10'd8);
        send_head();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(tx_bytes[k]);
            send_byte(tx_bytes[k]);
        end
        check("ovr_after4_err", ovr_err_o, 1'b0);
        check("ovr_after4_head", {24'd0, byte_o}, 32'h11);
        send_byte(tx_bytes[4]);
        check("ovr_after5_err", ovr_err_o, 1'b1);
        for (int k = 5; k < 8; k++) send_byte(tx_bytes[k]);
        send_tail(good_crc, 1'b1);
        tick(2);
        check("ovr_done", done_cnt - d0, 32'd1);
        check("ovr_crc_err", crc_err_o, 1'b0);
        check("ovr_valid_held", byte_valid_o, 1'b1);
        byte_ready_i = 1'b1;
        wait_drain("ovr_drain");
        tick(1);
        check("ovr_valid_empty", byte_valid_o, 1'b0);
        check("ovr_err_sticky", ovr_err_o, 1'b1);

        // Start-bit timeout after 15 strobes
        d0 = done_cnt;
        do_start(MD_READ, 10'd4);
        check("tmo_ovr_clr", ovr_err_o, 1'b0);
        for (int i = 0; i < 14; i++) send_bit(1'b1);
        check("tmo_14_err", tmo_err_o, 1'b0);
        check("tmo_14_busy", busy_o, 1'b1);
        check("tmo_14_done", done_cnt - d0, 32'd0);
        send_bit(1'b1);
        check("tmo_15_err", tmo_err_o, 1'b1);
        check("tmo_15_busy", busy_o, 1'b0);
        check("tmo_15_done", done_cnt - d0, 32'd1);

        // Busy wait: low for 10 strobes, released on the 11th
        d0 = done_cnt;
        do_start(MD_BUSY, 10'd4);
        check("busyw_tmo_clr", tmo_err_o, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        check("busyw_10_busy", busy_o, 1'b1);
        check("busyw_10_done", done_cnt - d0, 32'd0);
        send_bit(1'b1);
        check("busyw_11_done", done_cnt - d0, 32'd1);
        check("busyw_11_busy", busy_o, 1'b0);
        check("busyw_tmo_err", tmo_err_o, 1'b0);

        // Abort in the middle of byte 2
        load_deadbeef();
        byte_ready_i = 1'b0;
        d0 = done_cnt;
        do_start(MD_READ, 10'd4);
        send_head();
        send_byte(tx_bytes[0]);
        for (int i = 7; i >= 4; i--) send_bit(tx_bytes[1][i]);
        check("abort_pre_valid", byte_valid_o, 1'b1);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", byte_valid_o, 1'b0);
        tick(4);
        check("abort_no_done", done_cnt - d0, 32'd0);
        good_read("read2");

        // Reset mid-transfer: abandoned without done
        d0 = done_cnt;
        do_start(MD_READ, 10'd4);
        send_head();
        send_bit(1'b1);
        send_bit(1'b0);
        rstn_i = 1'b0;
        tick(2);
        rstn_i = 1'b1;
        tick(3);
        check("mrst_busy", busy_o, 1'b0);
        check("mrst_valid", byte_valid_o, 1'b0);
        check("mrst_no_done", done_cnt - d0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
